craft_decrypt_core: RTL and testbench



---
 rtl/craft_pkg.sv | 71 +++++++
 rtl/craft_decrypt_core_if.sv | 21 ++
 rtl/craft_key_schedule.sv | 28 ++
 rtl/craft_decrypt_core.sv | 137 +++++++++++++
 tb/tb_craft_decrypt_core.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/craft_pkg.sv
// Shared CRAFT constants: round-constant table, S-box, permutations, FSM states
// and the first published test vector (ciphertext derived by the reference encryptor below).
package craft_pkg;

  localparam int CRAFT_ROUNDS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } craft_state_e;

  // {a_i, b_i}: 4-bit and 3-bit LFSR sequences packed as one byte per round
  localparam logic [7:0] CRAFT_RC [32] = '{
    8'h11, 8'h84, 8'h42, 8'h25, 8'h96, 8'hc7, 8'h63, 8'hb1,
    8'h54, 8'ha2, 8'hd5, 8'he6, 8'hf7, 8'h73, 8'h31, 8'h14,
    8'h82, 8'h45, 8'h26, 8'h97, 8'hc3, 8'h61, 8'hb4, 8'h52,
    8'ha5, 8'hd6, 8'he7, 8'hf3, 8'h71, 8'h34, 8'h12, 8'h85
  };

  localparam logic [3:0] CRAFT_SBOX [16] = '{
    4'hc, 4'ha, 4'hd, 4'h3, 4'he, 4'hb, 4'hf, 4'h7,
    4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6
  };

  // Output nibble j takes input nibble P[j]; P happens to be its own inverse
  localparam int CRAFT_P    [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
  localparam int CRAFT_PINV [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
  localparam int CRAFT_Q    [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};

  localparam logic [127:0] CRAFT_TV1_KEY   = 128'h27a6781a43f364bc916708d5fbb5aefe;
  localparam logic [63:0]  CRAFT_TV1_TWEAK = 64'h54cd94ffd0670a58;
  localparam logic [63:0]  CRAFT_TV1_PT    = 64'h5734f006d8d88a3e;

  // Forward cipher, evaluated only at elaboration to derive the test-vector ciphertext
  function automatic logic [63:0] craft_encrypt(input logic [63:0]  pt,
                                                input logic [127:0] key,
                                                input logic [63:0]  tweak);
    logic [63:0] qt;
    logic [63:0] tks [4];
    logic [3:0]  m   [16];
    logic [3:0]  n   [16];
    logic [63:0] ct;
    qt = '0;
    for (int j = 0; j < 16; j++) qt[63-4*j -: 4] = tweak[63-4*CRAFT_Q[j] -: 4];
    tks[0] = key[127:64] ^ tweak;
    tks[1] = key[63:0]   ^ tweak;
    tks[2] = key[127:64] ^ qt;
    tks[3] = key[63:0]   ^ qt;
    for (int j = 0; j < 16; j++) m[j] = pt[63-4*j -: 4];
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 4; c++) begin
        m[c]   = m[c] ^ m[c+8] ^ m[c+12];
        m[c+4] = m[c+4] ^ m[c+12];
      end
      m[4] = m[4] ^ CRAFT_RC[r][7:4];
      m[5] = m[5] ^ CRAFT_RC[r][3:0];
      for (int j = 0; j < 16; j++) m[j] = m[j] ^ tks[r % 4][63-4*j -: 4];
      if (r != 31) begin
        for (int j = 0; j < 16; j++) n[j] = m[CRAFT_P[j]];
        for (int j = 0; j < 16; j++) m[j] = CRAFT_SBOX[n[j]];
      end
    end
    ct = '0;
    for (int j = 0; j < 16; j++) ct[63-4*j -: 4] = m[j];
    return ct;
  endfunction

  localparam logic [63:0] CRAFT_TV1_CT = craft_encrypt(CRAFT_TV1_PT, CRAFT_TV1_KEY, CRAFT_TV1_TWEAK);

endpackage

// File: rtl/craft_decrypt_core_if.sv
// Job/result handshake bundle between the ciphertext source, the decrypt core and the plaintext sink.
interface craft_decrypt_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  ciphertext;
  logic [127:0] key;
  logic [63:0]  tweak;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  plaintext;

  modport master (
    output in_valid, ciphertext, key, tweak, out_ready,
    input  in_ready, out_valid, plaintext
  );

  modport slave (
    input  in_valid, ciphertext, key, tweak, out_ready,
    output in_ready, out_valid, plaintext
  );
endinterface

// File: rtl/craft_key_schedule.sv
// CRAFT tweakey selector: returns TK[r mod 4] built from K0/K1 and T / Q(T).
module craft_key_schedule
  import craft_pkg::*;
(
  input  logic [127:0] key,
  input  logic [63:0]  tweak,
  input  logic [4:0]   r,
  output logic [63:0]  tk
);
  logic [63:0] tweak_perm;
  logic        unused_r_hi;

  assign unused_r_hi = ^r[4:2];

  always_comb begin
    tweak_perm = '0;
    for (int j = 0; j < 16; j++) tweak_perm[63-4*j -: 4] = tweak[63-4*CRAFT_Q[j] -: 4];
  end

  always_comb begin
    unique case (r[1:0])
      2'd0:    tk = key[127:64] ^ tweak;
      2'd1:    tk = key[63:0]   ^ tweak;
      2'd2:    tk = key[127:64] ^ tweak_perm;
      default: tk = key[63:0]   ^ tweak_perm;
    endcase
  end
endmodule

// File: rtl/craft_decrypt_core.sv
// Iterative CRAFT decryption, one inverse round per clock. Build option CRAFT_DEC_LATCH_KEY_EN
// captures key/tweak at job accept; otherwise the source holds them until the result is taken.
module craft_decrypt_core
  import craft_pkg::*;
#(
  parameter int ROUNDS = CRAFT_ROUNDS
) (
  input logic                 CLK100MHZ,
  input logic                 CPU_RESETN,
  craft_decrypt_core_if.slave bus
);
  localparam logic [4:0] LAST_K = 5'(ROUNDS - 1);

  craft_state_e fsm_q, fsm_d;
  logic [4:0]   k_q, k_d;
  logic [63:0]  blk_q, blk_d;
  logic         in_ready, out_valid, accept;
  logic [4:0]   rnd_i;
  logic [63:0]  tk, rc_word, round_in, round_out;
  logic [127:0] ks_key;
  logic [63:0]  ks_tweak;

  function automatic logic [63:0] sb(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 16; j++) y[63-4*j -: 4] = CRAFT_SBOX[x[63-4*j -: 4]];
    return y;
  endfunction

  function automatic logic [63:0] pn_inv(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 16; j++) y[63-4*j -: 4] = x[63-4*CRAFT_PINV[j] -: 4];
    return y;
  endfunction

  // Rows 0 and 1 absorb rows 2/3 and 3 respectively; applying it twice cancels out
  function automatic logic [63:0] mc(input logic [63:0] x);
    logic [63:0] y;
    y = x;
    for (int c = 0; c < 4; c++) begin
      y[63-4*c -: 4] = x[63-4*c -: 4] ^ x[31-4*c -: 4] ^ x[15-4*c -: 4];
      y[47-4*c -: 4] = x[47-4*c -: 4] ^ x[15-4*c -: 4];
    end
    return y;
  endfunction

  assign accept = (fsm_q == ST_IDLE) && bus.in_valid;

`ifdef CRAFT_DEC_LATCH_KEY_EN
  logic [127:0] key_q, key_d;
  logic [63:0]  tweak_q, tweak_d;

  always_comb begin
    key_d   = key_q;
    tweak_d = tweak_q;
    if (accept) begin
      key_d   = bus.key;
      tweak_d = bus.tweak;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      key_q   <= '0;
      tweak_q <= '0;
    end else begin
      key_q   <= key_d;
      tweak_q <= tweak_d;
    end
  end

  assign ks_key   = key_q;
  assign ks_tweak = tweak_q;
`else
  assign ks_key   = bus.key;
  assign ks_tweak = bus.tweak;
`endif

  // Round cycle k undoes encryption round 31-k
  assign rnd_i = LAST_K - k_q;

  craft_key_schedule u_key_schedule (
    .key   (ks_key),
    .tweak (ks_tweak),
    .r     (rnd_i),
    .tk    (tk)
  );

  assign rc_word   = {16'h0000, CRAFT_RC[rnd_i], 40'h0};
  assign round_in  = (k_q == 5'd0) ? blk_q : pn_inv(sb(blk_q));
  assign round_out = mc(round_in ^ rc_word ^ tk);

  always_comb begin
    fsm_d     = fsm_q;
    k_d       = k_q;
    blk_d     = blk_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          fsm_d = ST_RUN;
          k_d   = '0;
          blk_d = bus.ciphertext;
        end
      end
      ST_RUN: begin
        blk_d = round_out;
        k_d   = k_q + 5'd1;
        if (k_q == LAST_K) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      fsm_q <= ST_IDLE;
      k_q   <= '0;
      blk_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      k_q   <= k_d;
      blk_q <= blk_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.plaintext = blk_q;
endmodule

// File: tb/tb_craft_decrypt_core.sv
// Scoreboard bench for craft_decrypt_core: jobs are encrypted by a nibble-level reference model,
// decrypted by the core, and results/latency checked by an independent monitor.
module tb_craft_decrypt_core;
  import craft_pkg::*;

  localparam logic [127:0] TV_KEY = 128'h27a6781a43f364bc916708d5fbb5aefe;
  localparam logic [63:0]  TV_TW  = 64'h54cd94ffd0670a58;
  localparam logic [63:0]  TV_PT  = 64'h5734f006d8d88a3e;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  craft_decrypt_core_if bus ();

  craft_decrypt_core #(.ROUNDS(32)) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus)
  );

  typedef struct {
    logic [63:0] pt;
    int          acc;
    bit          neq;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         sbox_t [16] = '{12, 10, 13, 3, 14, 11, 15, 7, 8, 9, 1, 5, 0, 2, 4, 6};
  int         perm_t [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
  int         q_t    [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
  int         mix_t  [4][4] = '{'{1, 0, 1, 1}, '{0, 1, 0, 1}, '{0, 0, 1, 0}, '{0, 0, 0, 1}};
  logic [7:0] rc_t   [32];

  task automatic build_rc();
    logic [3:0] a;
    logic [2:0] b;
    a = 4'h1;
    b = 3'h1;
    for (int i = 0; i < 32; i++) begin
      rc_t[i] = {a, 1'b0, b};
      a = {a[1] ^ a[0], a[3:1]};
      b = {b[1] ^ b[0], b[2:1]};
    end
  endtask

  // Forward CRAFT on a 4x4 nibble matrix, rows = nibbles 4r..4r+3
  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [127:0] k,
                                              input logic [63:0] t);
    int st [16];
    int nx [16];
    int tks [4][16];
    logic [63:0] k0, k1, ct;
    k0 = k[127:64];
    k1 = k[63:0];
    for (int j = 0; j < 16; j++) begin
      tks[0][j] = int'(k0[63-4*j -: 4]) ^ int'(t[63-4*j -: 4]);
      tks[1][j] = int'(k1[63-4*j -: 4]) ^ int'(t[63-4*j -: 4]);
      tks[2][j] = int'(k0[63-4*j -: 4]) ^ int'(t[63-4*q_t[j] -: 4]);
      tks[3][j] = int'(k1[63-4*j -: 4]) ^ int'(t[63-4*q_t[j] -: 4]);
      st[j] = int'(pt[63-4*j -: 4]);
    end
    for (int r = 0; r < 32; r++) begin
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++) begin
          nx[4*row+col] = 0;
          for (int m = 0; m < 4; m++)
            if (mix_t[row][m] == 1) nx[4*row+col] ^= st[4*m+col];
        end
      st = nx;
      st[4] ^= int'(rc_t[r][7:4]);
      st[5] ^= int'(rc_t[r][3:0]);
      for (int j = 0; j < 16; j++) st[j] ^= tks[r % 4][j];
      if (r != 31) begin
        for (int j = 0; j < 16; j++) nx[j] = st[perm_t[j]];
        for (int j = 0; j < 16; j++) st[j] = sbox_t[nx[j]];
      end
    end
    ct = '0;
    for (int j = 0; j < 16; j++) ct[63-4*j -: 4] = 4'(st[j]);
    return ct;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one job; returns #1 after the accept edge with in_valid dropped
  task automatic send(input logic [63:0] ct, input logic [127:0] k, input logic [63:0] t,
                      input logic [63:0] exp_pt, input bit neq, output int acc);
    int   n;
    exp_t e;
    n = 0;
    bus.in_valid = 1'b0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!bus.in_ready && n < 300);
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready still %b after %0d cycles", bus.in_ready, n);
      acc = -1;
      return;
    end
    bus.in_valid   = 1'b1;
    bus.ciphertext = ct;
    bus.key        = k;
    bus.tweak      = t;
    acc   = cyc + 1;
    e.pt  = exp_pt;
    e.acc = acc;
    e.neq = neq;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    bit   prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (bus.out_valid && !prev_ov) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: out_valid=1 at cycle %0d, required 0", cyc);
          end else begin
            check("out_valid_latency", 64'(cyc), 64'(sbq[0].acc + 32));
          end
        end
        if (bus.out_valid && bus.out_ready && sbq.size() > 0) begin
          e = sbq.pop_front();
          if (e.neq) begin
            checks++;
            if (bus.plaintext === e.pt) begin
              errors++;
              $display("FAIL corrupted_key: got %h required a value other than %h",
                       bus.plaintext, e.pt);
            end
          end else begin
            check("plaintext", bus.plaintext, e.pt);
          end
        end
        prev_ov = bus.out_valid;
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $finish;
  end

  initial begin : main
    int          acc, last_acc;
    logic [127:0] rk;
    logic [63:0]  rt, rp;
    bit           corrupt_neq;

    build_rc();
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.ciphertext = '0;
    bus.key        = '0;
    bus.tweak      = '0;

    repeat (3) @(negedge clk);
    #2;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_plaintext", bus.plaintext, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      check("idle_in_ready", 64'(bus.in_ready), 64'd1);
      check("idle_out_valid", 64'(bus.out_valid), 64'd0);
      check("idle_plaintext", bus.plaintext, 64'd0);
    end

    check("tv1_model_decrypts", ref_encrypt(TV_PT, TV_KEY, TV_TW), CRAFT_TV1_CT);

    send(CRAFT_TV1_CT, TV_KEY, TV_TW, TV_PT, 1'b0, acc);
    repeat (32) @(negedge clk);
    #2;
    check("tk_at_k31", dut.tk, 64'h736BECE593946EE4);
    drain();

    bus.out_ready = 1'b0;
    send(CRAFT_TV1_CT, TV_KEY, TV_TW, TV_PT, 1'b0, acc);
    begin
      int n;
      n = 0;
      while (!bus.out_valid && n < 100) begin
        @(negedge clk);
        #3;
        n++;
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      bus.in_valid   = 1'b1;
      bus.ciphertext = 64'h0123456789abcdef;
      #2;
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_plaintext", bus.plaintext, TV_PT);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.ciphertext = CRAFT_TV1_CT;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #3;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    drain();

    last_acc = -1;
    for (int n = 0; n < 100; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rt = {$urandom, $urandom};
      rp = {$urandom, $urandom};
      send(ref_encrypt(rp, rk, rt), rk, rt, rp, 1'b0, acc);
      if (n > 0) check("accept_spacing", 64'(acc - last_acc), 64'd34);
      last_acc = acc;
    end
    drain();

    rk = {$urandom, $urandom, $urandom, $urandom};
    rt = {$urandom, $urandom};
    rp = {$urandom, $urandom};
    send(ref_encrypt(rp, rk, rt), rk, rt, rp, 1'b0, acc);
    repeat (18) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sbq.delete();
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_plaintext", bus.plaintext, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      check("post_rst_no_out_valid", 64'(bus.out_valid), 64'd0);
    end
    rk = {$urandom, $urandom, $urandom, $urandom};
    rt = {$urandom, $urandom};
    rp = {$urandom, $urandom};
    send(ref_encrypt(rp, rk, rt), rk, rt, rp, 1'b0, acc);
    drain();

`ifdef CRAFT_DEC_LATCH_KEY_EN
    corrupt_neq = 1'b0;
`else
    corrupt_neq = 1'b1;
`endif
    send(CRAFT_TV1_CT, TV_KEY, TV_TW, TV_PT, corrupt_neq, acc);
    @(negedge clk);
    bus.key = TV_KEY ^ 128'h1;
    drain();
    bus.key = TV_KEY;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
